// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port data RAM: req/gnt accept, RAM sequencing, registered read return.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_READ
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic        r_rvalid0;
  logic        r_rvalid1;

  logic        w_prefer1;
  logic        w_win;
  logic        w_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_prefer1 = ~r_last;
`else
  // last is still tracked for observability but never steers a tie here
  assign w_prefer1 = 1'b0 & r_last;
`endif

  assign w_win   = m1_req & (~m0_req | w_prefer1);
  assign w_grant = (r_state == S_IDLE) & (m0_req | m1_req) & ~rst;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_grant) w_next = S_ACCESS;
      S_ACCESS: w_next = r_we ? S_IDLE : S_READ;
      S_READ:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rvalid0 <= (r_state == S_READ) & ~r_owner;
      r_rvalid1 <= (r_state == S_READ) & r_owner;
      if (w_grant) begin
        r_last  <= w_win;
        r_owner <= w_win;
        r_we    <= w_win ? m1_we    : m0_we;
        r_addr  <= w_win ? m1_addr  : m0_addr;
        r_wdata <= w_win ? m1_wdata : m0_wdata;
      end
      if (r_state == S_READ) begin
        if (r_owner) r_rdata1 <= ram_dout;
        else         r_rdata0 <= ram_dout;
      end
    end
  end

  assign m0_gnt    = w_grant & ~w_win;
  assign m1_gnt    = w_grant & w_win;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign ram_wen   = (r_state == S_ACCESS) & r_we;
  assign ram_ren   = (r_state == S_ACCESS) & ~r_we;
  assign ram_addr  = r_addr;
  assign ram_din   = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (grant rule, busy window length, read latency, word-addressed memory).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        ram_ren, ram_wen, busy, owner;
  logic [15:0] ram_addr, ram_din;
  logic [15:0] ram_dout = '0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .owner(owner)
  );

  // Bench-side RAM, 256 words aliased on the low address byte, one-cycle read latency.
  logic [15:0] ram_mem [256];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_wen) ram_mem[ram_addr[7:0]] <= ram_din;
      if (ram_ren) ram_dout <= ram_mem[ram_addr[7:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Masters
  bit          rst_q;
  bit          pend [2];
  bit          p_we [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_wdata [2];
  bit          cont [2];

  // Reference model state
  logic [15:0] mdl_mem [256];
  int          free_at, acc_cyc, rd_cyc, rd_port, gnt_total;
  bit          acc_pend, acc_we, rd_pend, m_last, m_owner;
  logic [15:0] rd_val, e_addr, e_din;
  logic [15:0] e_rdata [2];

  task automatic new_req(input int p, input bit we, input logic [15:0] a, input logic [15:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom());
    a[7:0] = 8'($urandom_range(0, 31));
    return a;
  endfunction

  task automatic evaluate();
    bit eb, ew, er;
    bit erv [2];
    int win;
    if (rst) begin
      chk("gnt0_in_reset", {15'd0, m0_gnt}, 16'd0);
      chk("gnt1_in_reset", {15'd0, m1_gnt}, 16'd0);
      free_at = cyc + 1; acc_pend = 0; rd_pend = 0;
      m_last = 1'b1; m_owner = 1'b0; e_addr = '0; e_din = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      return;
    end
    eb = (cyc < free_at);
    erv[0] = 0; erv[1] = 0; ew = 0; er = 0;
    if (rd_pend && cyc == rd_cyc) begin
      erv[rd_port] = 1; e_rdata[rd_port] = rd_val; rd_pend = 0;
    end
    if (acc_pend && cyc == acc_cyc) begin
      ew = acc_we; er = !acc_we; acc_pend = 0;
    end
    chk("busy",      {15'd0, busy},      {15'd0, eb});
    chk("owner",     {15'd0, owner},     {15'd0, m_owner});
    chk("ram_wen",   {15'd0, ram_wen},   {15'd0, ew});
    chk("ram_ren",   {15'd0, ram_ren},   {15'd0, er});
    chk("ram_addr",  ram_addr, e_addr);
    chk("ram_din",   ram_din,  e_din);
    chk("m0_rvalid", {15'd0, m0_rvalid}, {15'd0, erv[0]});
    chk("m1_rvalid", {15'd0, m1_rvalid}, {15'd0, erv[1]});
    chk("m0_rdata",  m0_rdata, e_rdata[0]);
    chk("m1_rdata",  m1_rdata, e_rdata[1]);
    win = -1;
    if (!eb) begin
      if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = m_last ? 0 : 1;
`else
        win = 0;
`endif
      end else if (pend[0]) win = 0;
      else if (pend[1]) win = 1;
    end
    chk("m0_gnt", {15'd0, m0_gnt}, {15'd0, (win == 0)});
    chk("m1_gnt", {15'd0, m1_gnt}, {15'd0, (win == 1)});
    if (win >= 0) begin
      m_last = win[0]; m_owner = win[0];
      e_addr = p_addr[win]; e_din = p_wdata[win];
      acc_pend = 1; acc_cyc = cyc + 1; acc_we = p_we[win];
      if (p_we[win]) begin
        mdl_mem[p_addr[win][7:0]] = p_wdata[win];
        free_at = cyc + 2;
      end else begin
        rd_pend = 1; rd_cyc = cyc + 3; rd_port = win;
        rd_val = mdl_mem[p_addr[win][7:0]];
        free_at = cyc + 3;
      end
      pend[win] = 0;
      gnt_total++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++)
      if (cont[p] && !pend[p]) new_req(p, 1'b0, rand_addr(), 16'($urandom()));
    rst = rst_q;
    m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
    @(negedge clk);
    evaluate();
    cyc++;
  endtask

  task automatic run_until_grant();
    int start;
    start = gnt_total;
    for (int i = 0; i < 20 && gnt_total == start; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wdata[p] = '0; cont[p] = 0; e_rdata[p] = '0;
    end
    gnt_total = 0; free_at = 0; acc_pend = 0; rd_pend = 0;
    m_last = 1; m_owner = 0; e_addr = '0; e_din = '0;
    rst = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    mem_clr = 1; rst_q = 1;
    step(); step();
    mem_clr = 0; rst_q = 0;
    repeat (2) step();

    // Port 0 writes, then port 1 reads the same word back
    new_req(0, 1'b1, 16'h0010, 16'hBEEF);
    run_until_grant();
    repeat (3) step();
    new_req(1, 1'b0, 16'h0010, 16'h0000);
    run_until_grant();
    repeat (4) step();

    // Both ports hammering reads, then port 0 backs off
    cont[0] = 1; cont[1] = 1;
    repeat (15) step();
    cont[0] = 0;
    repeat (9) step();
    cont[1] = 0;
    repeat (6) step();

    // Reset in the READ cycle of a port-0 read, port 1 waiting
    new_req(0, 1'b0, 16'h0010, 16'h0000);
    run_until_grant();
    step();
    rst_q = 1;
    new_req(1, 1'b0, 16'h0010, 16'h0000);
    step();
    rst_q = 0;
    repeat (5) step();

    // Port 1 request during a port-0 write; its address changes before the grant
    new_req(0, 1'b1, 16'h0033, 16'h1234);
    run_until_grant();
    new_req(1, 1'b0, 16'h0044, 16'h0000);
    step();
    p_addr[1] = 16'h0055;
    repeat (5) step();

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 99) < 40)
          new_req(p, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom()));
      rst_q = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_q = 0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port data RAM between two bus masters: port 0, the CPU load/store path, and port 1, a loader/debug master that fills or inspects RAM. It accepts one request at a time through a req/gnt handshake and sequences the RAM enable, address and data lines. It returns read data to the owning port with a registered valid pulse. It sits between the masters and `ram`, so `ram` has exactly one driver.

## Interface
- No parameters. Data and address are fixed at 16 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `m0_req`, `m1_req`  in  1  access request; held high until the matching gnt.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; sampled on the grant edge.
- `m0_addr`, `m1_addr`  in  16  RAM address; passed through unmodified.
- `m0_wdata`, `m1_wdata`  in  16  write data.
- `m0_gnt`, `m1_gnt`  out  1  one-cycle acceptance pulse (combinational from IDLE and req).
- `m0_rvalid`, `m1_rvalid`  out  1  registered one-cycle read-complete pulse.
- `m0_rdata`, `m1_rdata`  out  16  last read data for that port; holds until that port's next read completes.
- `ram_ren`, `ram_wen`  out  1  RAM enables; never both high.
- `ram_addr`, `ram_din`  out  16  latched address and write data.
- `ram_dout`  in  16  RAM read data, valid the cycle after `ram_ren`.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  port that owns the current or most recent transaction.

## Operation
- FSM states: IDLE, ACCESS, READ.
- **IDLE**
  - If either req is high, choose a winner and pulse its gnt.
  - Latch the winner's we, addr and wdata, and the winner id into `owner`.
  - Go to ACCESS.
  - No req: stay in IDLE.
- **ACCESS**
  - Drive the latched address on `ram_addr`.
  - Write: `ram_wen`=1 with `ram_din` = latched wdata, then go to IDLE.
  - Read: `ram_ren`=1, then go to READ.
- **READ**
  - Register `ram_dout` into the owner's rdata at the end of the cycle.
  - Set the owner's rvalid for the following cycle only.
  - Go to IDLE.
- **Arbitration**
  - The `last` pointer records the most recently granted port.
  - With simultaneous requests, the port that is not `last` wins.
  - A single requester always wins.
  - `last` updates only on a grant.
- Requests arriving while `busy` are not granted; gnt stays low and req must remain high.
- The non-owner's rdata and rvalid are never disturbed.
- `ram_ren` and `ram_wen` are 0 outside ACCESS. `ram_addr` and `ram_din` hold their latched values.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - state = IDLE, `last` = 1 (port 0 wins the first tie), `owner` = 0.
  - All gnt, rvalid, `ram_ren`, `ram_wen` and `busy` = 0.
  - All rdata, `ram_addr` and `ram_din` = 0.
- Grant at cycle T:
  - Write: `ram_wen` high in T+1. Next grant possible in T+2.
  - Read: `ram_ren` high in T+1, `ram_dout` sampled in T+2, rvalid high in T+3. A new grant can also occur in T+3, concurrent with rvalid.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset mid-transaction abandons it: no rvalid and no RAM enable after the reset edge. A write already strobed is not undone.
- If a requester drops req in IDLE before gnt, no transaction occurs.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin with the `last` pointer, as described above.
  - Undefined: fixed priority; port 0 always wins a tie, so port 1 can starve under continuous port-0 traffic. `last` is still tracked, but it is not used for arbitration.

## Test plan
- Port 0 writes 0xBEEF to 0x0010:
  - `m0_gnt` at T, `ram_wen`/`ram_addr`=0x0010/`ram_din`=0xBEEF in T+1, `busy` low in T+2.
  - No rvalid on either port.
- Port 1 reads 0x0010 after that write:
  - `m1_gnt` at T, `ram_ren` in T+1, `m1_rvalid`=1 with `m1_rdata`=0xBEEF in T+3.
  - `m0_rdata` unchanged.
- Both ports request reads continuously from reset (round-robin defined):
  - Grants go 0,1,0,1, one every 3 cycles.
  - Each rvalid appears only on the owner's port.
- Macro undefined, both ports requesting continuously:
  - Every grant goes to port 0.
  - Port 1 is granted in the first IDLE cycle after `m0_req` falls.
- Assert `rst` in T+2 of a port-0 read:
  - `m0_rvalid` stays 0.
  - State is IDLE with all outputs 0 after the edge.
  - A new `m1_req` is granted in the cycle following reset release.
- `m1_req` asserted during a port-0 write's ACCESS cycle:
  - `m1_gnt` stays low until IDLE, then pulses.
  - `m1_addr` is latched at that edge, not earlier.
